// File: rtl/i2c_pkg.sv
// Shared I2C definitions: SDA source-select encoding and the released (idle) bus level.
package i2c_pkg;

    typedef enum logic [1:0] {
        SDA_IDLE = 2'd0,
        SDA_LOW  = 2'd1,
        SDA_HIGH = 2'd2,
        SDA_TX   = 2'd3
    } sda_mode_t;

    localparam logic SDA_RELEASED = 1'b1;

endpackage

// File: rtl/i2c_sync_hi.sv
// N-stage synchronizer for an asynchronous level; every stage resets to the released bus level.
module i2c_sync_hi
    import i2c_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_reg[gi] <= SDA_RELEASED;
                    end else begin
                        stage_reg[gi] <= d;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_reg[gi] <= SDA_RELEASED;
                    end else begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/i2c_sda_sel.sv
// I2C master SDA source selector with pad enable and an optional arbitration-loss monitor.
// Define SDA_SEL_ARB_EN to build the sda_in synchronizer and the sticky arb_lost flag.
module i2c_sda_sel
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2  // legal range 2..4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sda_mode,
    input  logic       tx_out,
    input  logic       sda_in,
    input  logic       sample_en,
    output logic       sda_out,
    output logic       sda_oe,
    output logic       arb_lost,
    input  logic       arb_clr
);

    logic sda_sel;

    // Any undecodable mode (including X/Z in simulation) falls to the released level.
    always_comb begin
        sda_sel = SDA_RELEASED;
        case (sda_mode)
            SDA_IDLE: sda_sel = SDA_RELEASED;
            SDA_LOW:  sda_sel = 1'b0;
            SDA_HIGH: sda_sel = SDA_RELEASED;
            SDA_TX:   sda_sel = tx_out;
            default:  sda_sel = SDA_RELEASED;
        endcase
    end

    assign sda_out = sda_sel;
    assign sda_oe  = ~sda_sel;

`ifdef SDA_SEL_ARB_EN

    logic sda_sync;
    logic arb_set;
    logic arb_lost_reg;

    i2c_sync_hi #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (sda_in),
        .q  (sda_sync)
    );

    // We released the line while transmitting, yet the bus reads low: someone else owns it.
    assign arb_set = sample_en && (sda_mode == SDA_TX) && tx_out && !sda_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_lost_reg <= 1'b0;
        end else if (arb_set) begin
            arb_lost_reg <= 1'b1;
        end else if (arb_clr) begin
            arb_lost_reg <= 1'b0;
        end
    end

    assign arb_lost = arb_lost_reg;

`else

    logic unused_arb_inputs;

    assign unused_arb_inputs = ^{clk, rst, sda_in, sample_en, arb_clr, (SYNC_STAGES > 0)};
    assign arb_lost          = 1'b0;

`endif

endmodule

// File: tb/tb_i2c_sda_sel.sv
// Directed self-checking bench for i2c_sda_sel: table-driven SDA mapping plus arbitration sequences.
`timescale 1ns/1ps
module tb_i2c_sda_sel;

    localparam int SYNC_STAGES = 2;

    typedef struct {
        logic [1:0] mode;
        logic       tx;
        logic       exp_out;
        logic       exp_oe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sda_mode = 2'd0;
    logic       tx_out = 1'b0;
    logic       sda_in = 1'b1;
    logic       sample_en = 1'b0;
    logic       arb_clr = 1'b0;
    logic       sda_out;
    logic       sda_oe;
    logic       arb_lost;

    int errors = 0;
    int checks = 0;

    vec_t vecs[11];

    i2c_sda_sel #(
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sda_mode (sda_mode),
        .tx_out   (tx_out),
        .sda_in   (sda_in),
        .sample_en(sample_en),
        .sda_out  (sda_out),
        .sda_oe   (sda_oe),
        .arb_lost (arb_lost),
        .arb_clr  (arb_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end else begin
            $display("ok   %s: %b", nm, act);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        pat = 8'b01010101;
        vecs[0] = '{mode: 2'd0, tx: 1'b0, exp_out: 1'b1, exp_oe: 1'b0};
        vecs[1] = '{mode: 2'd1, tx: 1'b1, exp_out: 1'b0, exp_oe: 1'b1};
        vecs[2] = '{mode: 2'd2, tx: 1'b0, exp_out: 1'b1, exp_oe: 1'b0};
        for (int i = 0; i < 8; i++) begin
            vecs[3+i] = '{mode: 2'd3, tx: pat[i], exp_out: pat[i], exp_oe: ~pat[i]};
        end

        // Reset state
        #1;
        chk("reset_arb_lost", arb_lost, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Combinational SDA mapping, one vector per 11 ns
        for (int i = 0; i < 11; i++) begin
            sda_mode = vecs[i].mode;
            tx_out   = vecs[i].tx;
            #1;
            chk($sformatf("vec%0d_sda_out m=%0d tx=%b", i, vecs[i].mode, vecs[i].tx), sda_out, vecs[i].exp_out);
            chk($sformatf("vec%0d_sda_oe", i), sda_oe, vecs[i].exp_oe);
            #10;
        end

`ifdef SDA_SEL_ARB_EN
        // Set after synchronizer latency; one edge too early must not set
        @(negedge clk);
        sda_mode = 2'd3; tx_out = 1'b1; sda_in = 1'b0; sample_en = 1'b0;
        repeat (SYNC_STAGES - 1) @(negedge clk);
        sample_en = 1'b1;
        @(posedge clk); #1;
        chk("arb_not_yet_synced", arb_lost, 1'b0);
        @(posedge clk); #1;
        chk("arb_set", arb_lost, 1'b1);

        // Sticky
        @(negedge clk);
        sample_en = 1'b0; tx_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("arb_sticky", arb_lost, 1'b1);

        // Clear
        @(negedge clk);
        arb_clr = 1'b1;
        @(posedge clk); #1;
        chk("arb_clear", arb_lost, 1'b0);

        // Set wins over clear in the same cycle
        @(negedge clk);
        tx_out = 1'b1; sample_en = 1'b1; arb_clr = 1'b1;
        @(posedge clk); #1;
        chk("arb_set_beats_clr", arb_lost, 1'b1);
        @(negedge clk);
        sample_en = 1'b0;
        @(posedge clk); #1;
        chk("arb_clear2", arb_lost, 1'b0);
        @(negedge clk);
        arb_clr = 1'b0;

        // No false loss: driving low ourselves, or not in TX mode
        tx_out = 1'b0; sample_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_loss_tx0", arb_lost, 1'b0);
        @(negedge clk);
        sda_mode = 2'd2; tx_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_loss_mode2", arb_lost, 1'b0);

        // Bus genuinely high: no loss
        @(negedge clk);
        sda_mode = 2'd3; sda_in = 1'b1; sample_en = 1'b0;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        @(negedge clk);
        sample_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("no_loss_bus_high", arb_lost, 1'b0);

        // Asynchronous reset while arb_lost=1
        @(negedge clk);
        sda_in = 1'b0;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1;
        chk("arb_set_before_rst", arb_lost, 1'b1);
        @(negedge clk);
        sample_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_clear", arb_lost, 1'b0);
        sda_mode = 2'd1;
        #1;
        chk("rst_sda_out_low", sda_out, 1'b0);
        chk("rst_sda_oe_low", sda_oe, 1'b1);
        sda_mode = 2'd3; tx_out = 1'b1;
        #1;
        chk("rst_sda_out_tx", sda_out, 1'b1);

        // Synchronizer restarts at the released level
        @(negedge clk);
        rst = 1'b0; sample_en = 1'b1;
        @(posedge clk); #1;
        chk("sync_reset_high", arb_lost, 1'b0);
        @(negedge clk);
        sample_en = 1'b0;
`else
        // Monitor absent: set condition must never raise arb_lost
        @(negedge clk);
        sda_mode = 2'd3; tx_out = 1'b1; sda_in = 1'b0; sample_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk($sformatf("arb_tied_low_%0d", i), arb_lost, 1'b0);
        end
        @(negedge clk);
        sample_en = 1'b0;
        rst = 1'b1;
        #1;
        sda_mode = 2'd1;
        #1;
        chk("rst_sda_out_low", sda_out, 1'b0);
        chk("rst_sda_oe_low", sda_oe, 1'b1);
        rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_sda_sel.md
Name: i2c_sda_sel

Overview:
- I2C master SDA output selector between the transmit shifter / controller FSM and the open-drain pad.
- Maps a 2-bit mode from the controller to the SDA level: constant high, constant low, or serial transmit data.
- Also produces the pad output enable.
- Provides a clocked arbitration-loss monitor that compares the driven SDA level with the synchronized bus level.

Parameters:
- SYNC_STAGES, 2, depth of the sda_in synchronizer chain; legal values 2..4.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sda_mode  input  2  SDA source select; encoding under Behaviour.
- tx_out  input  1  serial bit from the transmit shift register.
- sda_in  input  1  raw SDA pad level, asynchronous to clk.
- sample_en  input  1  single-cycle strobe marking the SCL-high sample point.
- sda_out  output  1  selected SDA level; 1 = release, 0 = drive low.
- sda_oe  output  1  pad pull-down enable; equals the inverse of sda_out.
- arb_lost  output  1  sticky arbitration-lost flag.
- arb_clr  input  1  synchronous clear of arb_lost.

Behaviour:
- sda_out is purely combinational from sda_mode and tx_out; no clock latency. It must settle within the same delta/cycle, and clk does not need to be running.
  - mode 0 (SDA_IDLE) -> 1.
  - mode 1 (SDA_LOW, start/ack/data-low) -> 0.
  - mode 2 (SDA_HIGH, stop/release/nack) -> 1.
  - mode 3 (SDA_TX) -> tx_out, bit for bit.
- If sda_mode contains X/Z, sda_out = 1, i.e. the bus is released as a fail-safe default.
- sda_oe = ~sda_out at all times, combinational.
- Synchronizer:
  - SYNC_STAGES flops clocked by clk.
  - All stages reset to 1, the idle bus level.
  - sda_sync is the last stage.
- arb_lost:
  - Resets to 0.
  - Sets on a clk edge where sample_en=1 AND sda_mode==3 AND tx_out==1 AND sda_sync==0. This means the master released the line but another master holds it low.
  - Once set, stays 1 until arb_clr=1 or rst.
  - If arb_clr and the set condition occur in the same cycle, set wins.
  - Modes 0-2 never set it.
- Reset mid-operation clears arb_lost and the synchronizer asynchronously. sda_out/sda_oe are unaffected by rst because they are combinational.

Optional Feature:
- Macro: SDA_SEL_ARB_EN.
- Defined: the synchronizer and arb_lost logic are present as described.
- Undefined: no flops are instantiated, arb_lost is tied to 0, and sda_in, sample_en and arb_clr are ignored. The sda_out/sda_oe behaviour is identical in both cases.

Decomposition:
- Shared package i2c_pkg:
  - typedef enum logic [1:0] sda_mode_t {SDA_IDLE=0, SDA_LOW=1, SDA_HIGH=2, SDA_TX=3}.
  - Constant SDA_RELEASED = 1'b1.
- One sub-module: i2c_sync_hi, a parameterized N-stage synchronizer with reset value 1. It is instantiated only under SDA_SEL_ARB_EN.

Test Plan:
- sda_mode=0 -> sda_out=1, sda_oe=0, checked 1 ns after the change.
- sda_mode=1 -> sda_out=0, sda_oe=1; sda_mode=2 -> sda_out=1, sda_oe=0.
- sda_mode=3; drive tx_out with bits of 8'b01010101, LSB first, one bit per 11 ns -> sda_out equals each bit 1 ns after it is applied.
- Arbitration (macro defined):
  - Set: sda_mode=3, tx_out=1, sda_in=0, run SYNC_STAGES+1 clocks, then pulse sample_en -> arb_lost=1 on the next edge.
  - Clear: pulse arb_clr -> arb_lost=0.
- No false loss: sda_mode=3, tx_out=0, sda_in=0, with sample_en pulses -> arb_lost stays 0. Same with sda_mode=2.
- Assert rst while arb_lost=1 -> arb_lost=0 immediately without a clock edge; sda_out still tracks sda_mode.
